// File: rtl/pcie_phy_pkg.sv
// ---------------------------------------------------------------------------
// pcie_phy_pkg
//   Shared PIPE-interface constants and configuration helpers for the PHY
//   receive path.
//   Contents:
//     PIPEWIDTH_*           legal per-lane PIPE widths in bits
//     DEF_GENn_PIPEWIDTH    default per-generation PIPE widths
//     gen_to_width()        maps a link generation to its PIPE width
//                           (0 when the generation is not 1..5)
//     lanes_legal()         checks a lane count against {1,2,4,8,16}
//                           and the instantiated maximum
//     beats_minus_one()     number of PIPE beats per 32-bit word, minus one
// ---------------------------------------------------------------------------
package pcie_phy_pkg;

  localparam int PIPEWIDTH_8  = 8;
  localparam int PIPEWIDTH_16 = 16;
  localparam int PIPEWIDTH_32 = 32;

  localparam int DEF_GEN1_PIPEWIDTH = PIPEWIDTH_8;
  localparam int DEF_GEN2_PIPEWIDTH = PIPEWIDTH_16;
  localparam int DEF_GEN3_PIPEWIDTH = PIPEWIDTH_32;
  localparam int DEF_GEN4_PIPEWIDTH = PIPEWIDTH_32;
  localparam int DEF_GEN5_PIPEWIDTH = PIPEWIDTH_32;

  // A return value of 0 doubles as the "illegal generation" indication.
  function automatic int gen_to_width(
    input logic [2:0] gen,
    input int         w1,
    input int         w2,
    input int         w3,
    input int         w4,
    input int         w5
  );
    case (gen)
      3'd1:    return w1;
      3'd2:    return w2;
      3'd3:    return w3;
      3'd4:    return w4;
      3'd5:    return w5;
      default: return 0;
    endcase
  endfunction

  function automatic logic lanes_legal(
    input logic [4:0] n,
    input int         max_lanes
  );
    case (n)
      5'd1, 5'd2, 5'd4, 5'd8, 5'd16: return (int'(n) <= max_lanes);
      default:                       return 1'b0;
    endcase
  endfunction

  // 8-bit PIPE -> 4 beats, 16-bit -> 2 beats, 32-bit (or illegal) -> 1 beat.
  function automatic int beats_minus_one(input int pw);
    case (pw)
      PIPEWIDTH_8:  return 3;
      PIPEWIDTH_16: return 1;
      default:      return 0;
    endcase
  endfunction

endpackage

// File: rtl/rx_packer_fifo.sv
// ---------------------------------------------------------------------------
// rx_packer_fifo
//   Synchronous FIFO holding packed lane words. The head entry is presented
//   combinationally so that a word pushed in one cycle is visible in the
//   next; the storage is a shallow register file rather than block RAM for
//   that reason (a registered RAM read would add a cycle of latency).
//   A push while full is accepted only when a pop happens in the same cycle.
//   Ports:
//     clk        clock
//     srst       synchronous active-high reset (pointers and count)
//     push       write push_data at the tail
//     push_data  WIDTH-bit data to write
//     pop        remove the head entry (ignored when empty)
//     head_data  current head entry (meaningless while empty)
//     full       DEPTH entries stored
//     empty      no entries stored
// ---------------------------------------------------------------------------
module rx_packer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  // Pop frees the slot the tail is about to write when the FIFO is full.
  assign do_push   = push && !srst && (!full || do_pop);
  assign head_data = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

endmodule

// File: rtl/rx_lane_packer.sv
// ---------------------------------------------------------------------------
// rx_lane_packer
//   Collects per-lane PIPE beats (8/16/32 bits depending on link generation)
//   into one 32-bit word per lane and queues the assembled multi-lane word
//   into an output FIFO. Active input lanes occupy the top LANESNUMBER slots
//   of inData; output words are right-aligned (lane 0 in slot 0) with unused
//   slots forced to zero.
//   Ports:
//     clk          clock
//     reset        synchronous active-high reset
//     GEN          link generation 1..5 (selects PIPE width)
//     LANESNUMBER  active lane count 1/2/4/8/16
//     inValid      qualifies inData/inDataK
//     inData       MAX_LANES x 32-bit lane slots
//     inDataK      MAX_LANES x 4 per-byte K flags
//     outValid     head word available
//     outReady     consumer accepts the head word
//     outData      packed 32-bit word per lane
//     outDataK     K flags aligned with outData
//     outLanes     lane count captured with the word
//     overflow     sticky: a completed word was dropped on a full FIFO
//     cfgError     GEN or LANESNUMBER currently illegal
// ---------------------------------------------------------------------------
module rx_lane_packer
  import pcie_phy_pkg::*;
#(
  parameter int MAX_LANES      = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int GEN1_PIPEWIDTH = DEF_GEN1_PIPEWIDTH,
  parameter int GEN2_PIPEWIDTH = DEF_GEN2_PIPEWIDTH,
  parameter int GEN3_PIPEWIDTH = DEF_GEN3_PIPEWIDTH,
  parameter int GEN4_PIPEWIDTH = DEF_GEN4_PIPEWIDTH,
  parameter int GEN5_PIPEWIDTH = DEF_GEN5_PIPEWIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             GEN,
  input  logic [4:0]             LANESNUMBER,
  input  logic                   inValid,
  input  logic [MAX_LANES*32-1:0] inData,
  input  logic [MAX_LANES*4-1:0]  inDataK,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [MAX_LANES*32-1:0] outData,
  output logic [MAX_LANES*4-1:0]  outDataK,
  output logic [4:0]             outLanes,
  output logic                   overflow,
  output logic                   cfgError
);

  localparam int DATA_W = MAX_LANES * 32;
  localparam int K_W    = MAX_LANES * 4;
  localparam int WORD_W = DATA_W + K_W + 5;

  // -------------------------------------------------------------------------
  // Configuration decode
  // -------------------------------------------------------------------------
  logic [2:0] gen_prev_reg;
  logic [4:0] lanes_prev_reg;
  logic [1:0] beat_cnt_reg;
  logic [1:0] beat_cnt_next;
  logic       overflow_reg;

  int   pw_bits;
  int   nbytes;
  int   beats_m1;
  int   eff_beat;
  int   off_bytes;
  logic cfg_ok;
  logic cfg_change;
  logic take;
  logic complete;

  always_comb begin
    pw_bits  = gen_to_width(GEN, GEN1_PIPEWIDTH, GEN2_PIPEWIDTH, GEN3_PIPEWIDTH,
                            GEN4_PIPEWIDTH, GEN5_PIPEWIDTH);
    nbytes   = pw_bits / 8;
    beats_m1 = beats_minus_one(pw_bits);
    cfg_ok   = (pw_bits != 0) && lanes_legal(LANESNUMBER, MAX_LANES);

    // A configuration change restarts packing: the beat arriving in the
    // change cycle is beat 0 of a fresh word.
    cfg_change = (GEN != gen_prev_reg) || (LANESNUMBER != lanes_prev_reg);
    eff_beat   = cfg_change ? 0 : int'(beat_cnt_reg);
    off_bytes  = eff_beat * nbytes;

    take     = inValid && cfg_ok;
    complete = take && (eff_beat == beats_m1);

    beat_cnt_next = 2'(eff_beat);
    if (!cfg_ok) begin
      beat_cnt_next = '0;
    end else if (take) begin
      beat_cnt_next = complete ? 2'b00 : 2'(eff_beat + 1);
    end
  end

  assign cfgError = !cfg_ok;

  // -------------------------------------------------------------------------
  // Per-lane accumulators
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] push_d;
  logic [K_W-1:0]    push_k;

  for (genvar gi = 0; gi < MAX_LANES; gi++) begin : g_lane
    logic        lane_active;
    logic [31:0] src_d;
    logic [3:0]  src_k;
    logic [31:0] shifted_d;
    logic [3:0]  shifted_k;
    logic [31:0] acc_d_reg;
    logic [31:0] acc_d_next;
    logic [3:0]  acc_k_reg;
    logic [3:0]  acc_k_next;

    always_comb begin
      lane_active = (gi < int'(LANESNUMBER));

      // Output lane gi is fed from input slot MAX_LANES-LANESNUMBER+gi.
      src_d = '0;
      src_k = '0;
      for (int s = 0; s < MAX_LANES; s++) begin
        if (lane_active && (s == MAX_LANES - int'(LANESNUMBER) + gi)) begin
          src_d = inData[s*32 +: 32];
          src_k = inDataK[s*4 +: 4];
        end
      end

      // Move the beat's low bytes up to this beat's byte position; only the
      // PW/8 bytes starting at that offset are committed below.
      shifted_d = src_d << (8 * off_bytes);
      shifted_k = src_k << off_bytes;

      acc_d_next = cfg_change ? '0 : acc_d_reg;
      acc_k_next = cfg_change ? '0 : acc_k_reg;
      for (int b = 0; b < 4; b++) begin
        if (take && lane_active && (b >= off_bytes) && (b < off_bytes + nbytes)) begin
          acc_d_next[b*8 +: 8] = shifted_d[b*8 +: 8];
          acc_k_next[b]        = shifted_k[b];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        acc_d_reg <= '0;
        acc_k_reg <= '0;
      end else begin
        acc_d_reg <= acc_d_next;
        acc_k_reg <= acc_k_next;
      end
    end

    // The completing beat is folded in combinationally so the push happens
    // in the same cycle; inactive slots are zeroed before queuing.
    assign push_d[gi*32 +: 32] = lane_active ? acc_d_next : 32'h0;
    assign push_k[gi*4 +: 4]   = lane_active ? acc_k_next : 4'h0;
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [WORD_W-1:0] fifo_head;

  assign fifo_pop = !fifo_empty && outReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_reg   <= '0;
      overflow_reg   <= 1'b0;
      // Track the live configuration so leaving reset is not a "change".
      gen_prev_reg   <= GEN;
      lanes_prev_reg <= LANESNUMBER;
    end else begin
      beat_cnt_reg   <= beat_cnt_next;
      gen_prev_reg   <= GEN;
      lanes_prev_reg <= LANESNUMBER;
      if (complete && fifo_full && !fifo_pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign overflow = overflow_reg;

  // -------------------------------------------------------------------------
  // Output FIFO: word = {lanes, K flags, data}
  // -------------------------------------------------------------------------
  rx_packer_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .srst      (reset),
    .push      (complete),
    .push_data ({LANESNUMBER, push_k, push_d}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Outputs read as zero whenever nothing is queued (including after reset).
  assign outValid = !fifo_empty;
  assign outData  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign outDataK = fifo_empty ? '0 : fifo_head[DATA_W +: K_W];
  assign outLanes = fifo_empty ? '0 : fifo_head[DATA_W+K_W +: 5];

endmodule

// File: tb/tb_rx_lane_packer.sv
module tb_rx_lane_packer;

  localparam int ML = 16;
  localparam int FD = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        GEN;
  logic [4:0]        LANESNUMBER;
  logic              inValid;
  logic [ML*32-1:0]  inData;
  logic [ML*4-1:0]   inDataK;
  logic              outValid;
  logic              outReady;
  logic [ML*32-1:0]  outData;
  logic [ML*4-1:0]   outDataK;
  logic [4:0]        outLanes;
  logic              overflow;
  logic              cfgError;

  logic [ML*32-1:0]  exp_d;
  logic [ML*4-1:0]   exp_k;

  int checks = 0;
  int errors = 0;

  rx_lane_packer #(
    .MAX_LANES  (ML),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .GEN         (GEN),
    .LANESNUMBER (LANESNUMBER),
    .inValid     (inValid),
    .inData      (inData),
    .inDataK     (inDataK),
    .outValid    (outValid),
    .outReady    (outReady),
    .outData     (outData),
    .outDataK    (outDataK),
    .outLanes    (outLanes),
    .overflow    (overflow),
    .cfgError    (cfgError)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit beat b on the top l slots: lane k carries byte {k,b} in its low
  // byte with garbage above; only lane 0 beat 2 carries a K flag.
  task automatic drive_g1(input int l, input int b);
    inData  = {ML{32'hDEADBEEF}};
    inDataK = {ML{4'hF}};
    for (int k = 0; k < l; k++) begin
      inData[(ML-l+k)*32 +: 32] = {24'hABCDEF, 8'(k*16 + b)};
      inDataK[(ML-l+k)*4 +: 4]  = {3'b111, (b == 2 && k == 0)};
    end
    inValid = 1'b1;
    $display("beat gen1 lanes=%0d beat=%0d", l, b);
  endtask

  task automatic build_g1_exp(input int l);
    exp_d = '0;
    exp_k = '0;
    for (int k = 0; k < l; k++) begin
      exp_d[k*32 +: 32] = {8'(k*16+3), 8'(k*16+2), 8'(k*16+1), 8'(k*16)};
    end
    exp_k[3:0] = 4'b0100;
  endtask

  task automatic drive_g3(input int i);
    inData  = {ML{32'h5A5A5A5A}};
    inDataK = {ML{4'hF}};
    inData[14*32 +: 32] = 32'hA0000000 + 32'(i*16);
    inData[15*32 +: 32] = 32'hA0000001 + 32'(i*16);
    inDataK[14*4 +: 4]  = 4'h3;
    inDataK[15*4 +: 4]  = 4'hC;
    inValid = 1'b1;
    $display("beat gen3 lanes=2 word=%0d", i);
  endtask

  task automatic build_g3_exp(input int i);
    exp_d = '0;
    exp_k = '0;
    exp_d[31:0]  = 32'hA0000000 + 32'(i*16);
    exp_d[63:32] = 32'hA0000001 + 32'(i*16);
    exp_k[7:0]   = 8'hC3;
  endtask

  initial begin
    reset       = 1'b1;
    GEN         = 3'd1;
    LANESNUMBER = 5'd4;
    inValid     = 1'b0;
    inData      = '0;
    inDataK     = '0;
    outReady    = 1'b1;

    // ---- reset state ----
    tick();
    tick();
    chk("rst_outValid", 512'(outValid), 512'(1'b0));
    chk("rst_outData",  512'(outData),  512'(0));
    chk("rst_outDataK", 512'(outDataK), 512'(0));
    chk("rst_outLanes", 512'(outLanes), 512'(0));
    chk("rst_overflow", 512'(overflow), 512'(1'b0));
    chk("rst_cfgError", 512'(cfgError), 512'(1'b0));
    reset = 1'b0;
    tick();

    // ---- GEN1 x4: four byte beats form one word per lane ----
    outReady = 1'b0;
    for (int b = 0; b < 4; b++) begin
      drive_g1(4, b);
      tick();
      if (b == 2) chk("g1x4_no_early_push", 512'(outValid), 512'(1'b0));
    end
    inValid = 1'b0;
    build_g1_exp(4);
    chk("g1x4_outValid", 512'(outValid), 512'(1'b1));
    chk("g1x4_outData",  512'(outData),  512'(exp_d));
    chk("g1x4_outDataK", 512'(outDataK), 512'(exp_k));
    chk("g1x4_outLanes", 512'(outLanes), 512'(5'd4));
    tick();
    chk("g1x4_hold_data",  512'(outData),  512'(exp_d));
    chk("g1x4_hold_valid", 512'(outValid), 512'(1'b1));
    outReady = 1'b1;
    tick();
    chk("g1x4_popped", 512'(outValid), 512'(1'b0));

    // ---- GEN2 x16: 0x1111 then 0x2222 on all lanes ----
    GEN         = 3'd2;
    LANESNUMBER = 5'd16;
    inData      = {ML{32'hFFFF1111}};
    inDataK     = {ML{4'b1101}};
    inValid     = 1'b1;
    $display("beat gen2 lanes=16 beat=0");
    tick();
    chk("g2x16_no_early_push", 512'(outValid), 512'(1'b0));
    inData  = {ML{32'hEEEE2222}};
    inDataK = {ML{4'b1110}};
    $display("beat gen2 lanes=16 beat=1");
    tick();
    inValid = 1'b0;
    exp_d = {ML{32'h22221111}};
    exp_k = {ML{4'b1001}};
    chk("g2x16_outValid", 512'(outValid), 512'(1'b1));
    chk("g2x16_outData",  512'(outData),  512'(exp_d));
    chk("g2x16_outDataK", 512'(outDataK), 512'(exp_k));
    chk("g2x16_outLanes", 512'(outLanes), 512'(5'd16));
    tick();
    chk("g2x16_popped", 512'(outValid), 512'(1'b0));

    // ---- GEN3 overflow: FIFO_DEPTH+1 words with outReady low ----
    GEN         = 3'd3;
    LANESNUMBER = 5'd2;
    outReady    = 1'b0;
    for (int i = 0; i <= FD; i++) begin
      drive_g3(i);
      tick();
      if (i == 0) chk("ovf_first_valid", 512'(outValid), 512'(1'b1));
      if (i == FD - 1) chk("ovf_not_yet", 512'(overflow), 512'(1'b0));
    end
    inValid = 1'b0;
    build_g3_exp(0);
    chk("ovf_flag",      512'(overflow), 512'(1'b1));
    chk("ovf_head_data", 512'(outData),  512'(exp_d));
    chk("ovf_head_k",    512'(outDataK), 512'(exp_k));
    chk("ovf_lanes",     512'(outLanes), 512'(5'd2));
    outReady = 1'b1;
    for (int i = 0; i < FD; i++) begin
      build_g3_exp(i);
      chk("drain_valid", 512'(outValid), 512'(1'b1));
      chk("drain_data",  512'(outData),  512'(exp_d));
      $display("drain word=%0d data=%0h", i, outData[63:0]);
      tick();
    end
    chk("drain_empty",  512'(outValid), 512'(1'b0));
    chk("ovf_sticky",   512'(overflow), 512'(1'b1));

    // ---- GEN1 lane-count change mid-word discards the partial word ----
    GEN         = 3'd1;
    LANESNUMBER = 5'd4;
    drive_g1(4, 0);
    tick();
    drive_g1(4, 1);
    tick();
    inValid     = 1'b0;
    LANESNUMBER = 5'd8;
    tick();
    chk("chg_no_push", 512'(outValid), 512'(1'b0));
    for (int b = 0; b < 4; b++) begin
      drive_g1(8, b);
      tick();
      if (b == 2) chk("chg_no_early_push", 512'(outValid), 512'(1'b0));
    end
    inValid = 1'b0;
    build_g1_exp(8);
    chk("chg_outValid", 512'(outValid), 512'(1'b1));
    chk("chg_outData",  512'(outData),  512'(exp_d));
    chk("chg_outDataK", 512'(outDataK), 512'(exp_k));
    chk("chg_outLanes", 512'(outLanes), 512'(5'd8));
    tick();
    chk("chg_single_word", 512'(outValid), 512'(1'b0));

    // ---- reset after 3 of 4 GEN1 beats ----
    LANESNUMBER = 5'd4;
    for (int b = 0; b < 3; b++) begin
      drive_g1(4, b);
      tick();
    end
    inValid = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_outValid", 512'(outValid), 512'(1'b0));
    chk("mrst_outData",  512'(outData),  512'(0));
    chk("mrst_outDataK", 512'(outDataK), 512'(0));
    chk("mrst_outLanes", 512'(outLanes), 512'(0));
    chk("mrst_overflow", 512'(overflow), 512'(1'b0));
    for (int b = 0; b < 4; b++) begin
      drive_g1(4, b);
      tick();
      if (b == 2) chk("mrst_no_early_push", 512'(outValid), 512'(1'b0));
    end
    inValid = 1'b0;
    build_g1_exp(4);
    chk("mrst_word_valid", 512'(outValid), 512'(1'b1));
    chk("mrst_word_data",  512'(outData),  512'(exp_d));
    tick();
    chk("mrst_one_word", 512'(outValid), 512'(1'b0));

    // ---- illegal configurations ----
    GEN         = 3'd6;
    LANESNUMBER = 5'd4;
    drive_g1(4, 0);
    #1;
    chk("cfg_gen6_err", 512'(cfgError), 512'(1'b1));
    for (int b = 0; b < 5; b++) begin
      drive_g1(4, b % 4);
      tick();
    end
    chk("cfg_gen6_no_push", 512'(outValid), 512'(1'b0));
    GEN         = 3'd1;
    LANESNUMBER = 5'd3;
    #1;
    chk("cfg_l3_err", 512'(cfgError), 512'(1'b1));
    for (int b = 0; b < 5; b++) begin
      drive_g1(3, b % 4);
      tick();
    end
    chk("cfg_l3_no_push", 512'(outValid), 512'(1'b0));
    LANESNUMBER = 5'd4;
    inValid     = 1'b0;
    #1;
    chk("cfg_legal_again", 512'(cfgError), 512'(1'b0));
    for (int b = 0; b < 4; b++) begin
      drive_g1(4, b);
      tick();
    end
    inValid = 1'b0;
    build_g1_exp(4);
    chk("cfg_recover_valid", 512'(outValid), 512'(1'b1));
    chk("cfg_recover_data",  512'(outData),  512'(exp_d));
    tick();
    chk("cfg_recover_drain", 512'(outValid), 512'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_lane_packer.md
RX_LANE_PACKER -- requirements
Module: rx_lane_packer

Interface
REQ-001 SHALL have parameter MAX_LANES, default 16, the maximum link width in lanes.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the output FIFO depth in words (power of 2, >=2).
REQ-003 SHALL have parameters GEN1_PIPEWIDTH..GEN5_PIPEWIDTH, defaults 8/16/32/32/32, the per-lane PIPE bits per beat, each one of {8,16,32}.
REQ-004 SHALL have port clk, input, 1, the single clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port GEN, input, 3, the link generation, 1..5.
REQ-007 SHALL have port LANESNUMBER, input, 5, the active lane count, one of 1/2/4/8/16.
REQ-008 SHALL have port inValid, input, 1, which qualifies inData/inDataK.
REQ-009 SHALL have port inData, input, MAX_LANES*32, the descrambled lane slots; lane i = bits [32i+31:32i]; the active lanes are the top LANESNUMBER slots.
REQ-010 SHALL have port inDataK, input, MAX_LANES*4, the per-byte K flags, with the same slot mapping as inData.
REQ-011 SHALL have port outValid, output, 1, meaning an output word is available.
REQ-012 SHALL have port outReady, input, 1, the consumer accept signal.
REQ-013 SHALL have port outData, output, MAX_LANES*32, the packed 32-bit words per lane, right-aligned (lane 0 at slot 0).
REQ-014 SHALL have port outDataK, output, MAX_LANES*4, the K flags aligned with outData.
REQ-015 SHALL have port outLanes, output, 5, the LANESNUMBER captured with the word.
REQ-016 SHALL have port overflow, output, 1, a sticky word-dropped flag.
REQ-017 SHALL have port cfgError, output, 1, asserted while GEN or LANESNUMBER is illegal.

Function
REQ-018 SHALL select PW = GENn_PIPEWIDTH for the current GEN, with beats per word B = 32/PW.
REQ-019 SHALL, on each inValid cycle, take the low PW bits (and PW/8 K bits) of every active slot and write them into that lane's accumulator at byte offset beatCnt*PW/8, with the first beat in the LSBs.
REQ-020 SHALL use a beatCnt that runs 0..B-1 and wraps to 0; when the beat at B-1 is taken, the assembled word for all lanes SHALL be pushed into the FIFO.
REQ-021 SHALL give the pushed word a latency of one cycle: outValid is asserted in the cycle after the completing beat, provided the FIFO was empty.
REQ-022 SHALL zero outData and outDataK in slots at or above outLanes.
REQ-023 SHALL pop the FIFO on outValid && outReady; outData, outDataK and outLanes SHALL hold stable while outValid && !outReady.
REQ-024 SHALL, on a push to a full FIFO without a simultaneous pop, drop the word, set overflow, and leave the FIFO contents unchanged.
REQ-025 SHALL, on a push to a full FIFO with a simultaneous pop, accept the push.
REQ-026 SHALL keep overflow set until reset.
REQ-027 SHALL, on a GEN or LANESNUMBER change relative to the previous cycle, clear beatCnt and discard the partial accumulation; a beat arriving in the change cycle SHALL be treated as beat 0 under the new configuration, and FIFO contents SHALL be kept.
REQ-028 SHALL, when the configuration is illegal, ignore inValid, hold beatCnt at 0, and assert cfgError combinationally.
REQ-029 SHALL, when PW=32 (B=1), push every inValid beat directly.

Reset
REQ-030 SHALL, while reset=1 at a clk edge, clear beatCnt, the accumulators, the FIFO pointers and overflow, and drive outValid=0, outData=0, outDataK=0 and outLanes=0.
REQ-031 SHALL abandon any partial word when reset is asserted mid-accumulation, with no push.

Structure
REQ-032 SHALL place the following in shared package pcie_phy_pkg: the PIPE-width constants, a gen-to-width function, and a legal-lane-count function.
REQ-033 SHALL implement the FIFO as sub-module rx_packer_fifo (synchronous, parametrised width/depth, with full/empty outputs).

Verification
REQ-034 SHALL cover: GEN=1, LANESNUMBER=4, 4 valid beats with lane k carrying bytes k0,k1,k2,k3 -> one word per lane = {k3,k2,k1,k0} at slot k, outValid one cycle after beat 4, upper slots 0.
REQ-035 SHALL cover: GEN=2, LANESNUMBER=16, beats 0x1111 then 0x2222 on all lanes -> each lane outputs 0x22221111, with K bits following their bytes.
REQ-036 SHALL cover: GEN=3, outReady=0, FIFO_DEPTH+1 beats -> FIFO_DEPTH words held, overflow=1, first word unchanged; then outReady=1 -> FIFO_DEPTH words drain in order.
REQ-037 SHALL cover: GEN=1, 2 beats, then LANESNUMBER 4->8 -> no push; the next 4 beats produce one 8-lane word with outLanes=8.
REQ-038 SHALL cover: reset asserted after 3 of 4 GEN1 beats -> all outputs 0; 4 further beats produce exactly one word.
REQ-039 SHALL cover: GEN=6 or LANESNUMBER=3 with inValid=1 -> cfgError=1, no pushes, outValid stays 0.
